// File: rtl/ccm_capture_compare.sv
// TimerA capture/compare channel: captures TAR on selected input edges, or flags
// a match between TAR and CCRn, with overflow and software-clear handling.
module ccm_capture_compare #(
  parameter int WIDTH = 16
) (
  input  logic             TimerClock,
  input  logic             reset,
  input  logic [WIDTH-1:0] TAR,
  input  logic             CAP,
  input  logic [1:0]       CM,
  input  logic [1:0]       CCIS,
  input  logic             SCS,
  input  logic             CCIA,
  input  logic             CCIB,
  input  logic             wCCR,
  input  logic [WIDTH-1:0] CCRin,
  input  logic             clrCCIFG,
  input  logic             clrCOV,
  output logic [WIDTH-1:0] CCRn,
  output logic             EQUn,
  output logic             CCIFG,
  output logic             COV,
  output logic             SCCI,
  output logic             CCI
);

  logic s1;
  logic s2;
  logic prev;
  logic cur;
  logic rise;
  logic fall;
  logic cap_event;
  logic cmp_event;
  logic eq_prev;

  always_comb begin
    CCI = 1'b0;
    unique case (CCIS)
      2'd0: CCI = CCIA;
      2'd1: CCI = CCIB;
      2'd2: CCI = 1'b0;
      2'd3: CCI = 1'b1;
      default: CCI = 1'b0;
    endcase
  end

  // With SCS set the edge detector looks one stage further down the chain.
  assign cur  = SCS ? s2 : s1;
  assign rise = cur & ~prev;
  assign fall = ~cur & prev;

  always_comb begin
    cap_event = 1'b0;
    if (CAP) begin
      unique case (CM)
        2'd0: cap_event = 1'b0;
        2'd1: cap_event = rise;
        2'd2: cap_event = fall;
        2'd3: cap_event = rise | fall;
        default: cap_event = 1'b0;
      endcase
    end
  end

  assign EQUn      = ~CAP & (TAR == CCRn);
  assign cmp_event = ~CAP & EQUn & ~eq_prev;

  always_ff @(posedge TimerClock or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      prev    <= 1'b0;
      eq_prev <= 1'b0;
    end else begin
      s1      <= CCI;
      s2      <= s1;
      prev    <= cur;
      eq_prev <= CAP ? 1'b0 : EQUn;
    end
  end

  // Hardware events win over software writes and clears on the same edge.
  always_ff @(posedge TimerClock or posedge reset) begin
    if (reset) begin
      CCRn  <= '0;
      CCIFG <= 1'b0;
      COV   <= 1'b0;
      SCCI  <= 1'b0;
    end else begin
      if (cap_event)
        CCRn <= TAR;
      else if (wCCR)
        CCRn <= CCRin;

      if (cap_event | cmp_event)
        CCIFG <= 1'b1;
      else if (clrCCIFG)
        CCIFG <= 1'b0;

      if (cap_event & CCIFG)
        COV <= 1'b1;
      else if (clrCOV)
        COV <= 1'b0;

      if (cmp_event)
        SCCI <= CCI;
    end
  end

endmodule

// File: tb/tb_ccm_capture_compare.sv
// Self-checking bench for ccm_capture_compare: compare, capture (sync/async),
// overflow, priority and asynchronous reset scenarios.
module tb_ccm_capture_compare;

  localparam int WIDTH = 16;

  logic             TimerClock;
  logic             reset;
  logic [WIDTH-1:0] tar;
  logic             cap;
  logic [1:0]       cm;
  logic [1:0]       ccis;
  logic             scs;
  logic             ccia;
  logic             ccib;
  logic             wccr;
  logic [WIDTH-1:0] ccrin;
  logic             clr_ccifg;
  logic             clr_cov;
  logic [WIDTH-1:0] ccrn;
  logic             equn;
  logic             ccifg;
  logic             cov;
  logic             scci;
  logic             cci;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_ccr_q[$];
  int               exp_lat_q[$];
  logic             exp_scci_q[$];

  ccm_capture_compare #(.WIDTH(WIDTH)) dut (
    .TimerClock(TimerClock), .reset(reset), .TAR(tar), .CAP(cap), .CM(cm),
    .CCIS(ccis), .SCS(scs), .CCIA(ccia), .CCIB(ccib), .wCCR(wccr),
    .CCRin(ccrin), .clrCCIFG(clr_ccifg), .clrCOV(clr_cov), .CCRn(ccrn),
    .EQUn(equn), .CCIFG(ccifg), .COV(cov), .SCCI(scci), .CCI(cci)
  );

  initial TimerClock = 1'b0;
  always #5 TimerClock = ~TimerClock;

  task automatic tick();
    @(posedge TimerClock);
    #1;
  endtask

  task automatic clear_flags();
    clr_ccifg = 1'b1;
    clr_cov   = 1'b1;
    tick();
    clr_ccifg = 1'b0;
    clr_cov   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tar = '0; cap = 1'b0; cm = 2'd0; ccis = 2'd0; scs = 1'b0;
    ccia = 1'b0; ccib = 1'b0; wccr = 1'b0; ccrin = '0;
    clr_ccifg = 1'b0; clr_cov = 1'b0;
    #12;
    checks++;
    if (ccrn !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ccrn got %h want 0000", ccrn); end
    checks++;
    if ({ccifg, cov, scci} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {ccifg, cov, scci}); end
    checks++;
    if (equn !== 1'b1) begin errors++; $display("[TB] FAIL reset_equn got %b want 1", equn); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_compare();
    logic seen;
    cap = 1'b0; ccis = 2'd3; tar = '0;
    wccr = 1'b1; ccrin = 16'h0005;
    tick();
    wccr = 1'b0;
    clear_flags();
    checks++;
    if (ccifg !== 1'b0) begin errors++; $display("[TB] FAIL cmp_pre_ccifg got %b want 0", ccifg); end
    seen = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      tar = WIDTH'(t);
      if (t == 5) exp_scci_q.push_back(1'b1);
      #1;
      checks++;
      if (equn !== (t == 5)) begin errors++; $display("[TB] FAIL cmp_equn tar=%0d got %b want %b", t, equn, (t == 5)); end
      tick();
      checks++;
      if (ccifg !== (t >= 5)) begin errors++; $display("[TB] FAIL cmp_ccifg tar=%0d got %b want %b", t, ccifg, (t >= 5)); end
      if (ccifg === 1'b1 && !seen && exp_scci_q.size() > 0) begin
        seen = 1'b1;
        checks++;
        if (scci !== exp_scci_q.pop_front()) begin errors++; $display("[TB] FAIL cmp_scci got %b want 1", scci); end
      end
    end
    // timer parked on the match must flag only once until EQUn drops
    tar = 16'h0005;
    tick();
    clr_ccifg = 1'b1;
    tick();
    clr_ccifg = 1'b0;
    repeat (3) tick();
    checks++;
    if (ccifg !== 1'b0) begin errors++; $display("[TB] FAIL cmp_stopped_once got %b want 0", ccifg); end
    tar = 16'h0006;
    tick();
    tar = 16'h0005;
    tick();
    checks++;
    if (ccifg !== 1'b1) begin errors++; $display("[TB] FAIL cmp_rearm got %b want 1", ccifg); end
    tar = 16'h0006;
    clr_ccifg = 1'b1;
    tick();
    tar = 16'h0005;
    tick();
    clr_ccifg = 1'b0;
    checks++;
    if (ccifg !== 1'b1) begin errors++; $display("[TB] FAIL cmp_clr_priority got %b want 1", ccifg); end
  endtask

  task automatic test_capture(input logic sync);
    int  lat;
    logic got;
    cap = 1'b1; cm = 2'd1; ccis = 2'd0; ccia = 1'b0; scs = sync; wccr = 1'b0;
    repeat (4) tick();
    clear_flags();
    tar = 16'h1234;
    ccia = 1'b1;
    exp_ccr_q.push_back(16'h1234);
    exp_lat_q.push_back(sync ? 3 : 2);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ccifg === 1'b1) begin lat = i; got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL cap_timeout scs=%b got no CCIFG within 8 edges", sync);
      void'(exp_ccr_q.pop_front());
      void'(exp_lat_q.pop_front());
    end else begin
      int e_lat;
      logic [WIDTH-1:0] e_ccr;
      e_lat = exp_lat_q.pop_front();
      e_ccr = exp_ccr_q.pop_front();
      if (lat !== e_lat) begin errors++; $display("[TB] FAIL cap_latency scs=%b got %0d want %0d", sync, lat, e_lat); end
      checks++;
      if (ccrn !== e_ccr) begin errors++; $display("[TB] FAIL cap_ccrn scs=%b got %h want %h", sync, ccrn, e_ccr); end
      checks++;
      if (cov !== 1'b0) begin errors++; $display("[TB] FAIL cap_cov scs=%b got %b want 0", sync, cov); end
      checks++;
      if (equn !== 1'b0) begin errors++; $display("[TB] FAIL cap_equn_masked got %b want 0", equn); end
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] vals[2] = '{16'h1111, 16'h2222};
    cap = 1'b1; cm = 2'd1; scs = 1'b0; ccia = 1'b0;
    repeat (4) tick();
    clear_flags();
    foreach (vals[k]) begin
      tar = vals[k];
      ccia = 1'b1;
      exp_ccr_q.push_back(vals[k]);
      repeat (3) tick();
      checks++;
      if (ccrn !== exp_ccr_q[0]) begin errors++; $display("[TB] FAIL ovf_ccrn%0d got %h want %h", k, ccrn, exp_ccr_q[0]); end
      void'(exp_ccr_q.pop_front());
      checks++;
      if (cov !== (k == 1)) begin errors++; $display("[TB] FAIL ovf_cov%0d got %b want %b", k, cov, (k == 1)); end
      ccia = 1'b0;
      repeat (2) tick();
    end
    clr_cov = 1'b1;
    tick();
    clr_cov = 1'b0;
    checks++;
    if ({ccifg, cov} !== 2'b10) begin errors++; $display("[TB] FAIL ovf_clrcov got ccifg,cov=%b want 10", {ccifg, cov}); end
  endtask

  task automatic test_priority();
    cap = 1'b1; cm = 2'd1; scs = 1'b0; ccia = 1'b0;
    wccr = 1'b1; ccrin = 16'hABCD;
    tick();
    wccr = 1'b0;
    checks++;
    if (ccrn !== 16'hABCD) begin errors++; $display("[TB] FAIL wccr_load got %h want abcd", ccrn); end
    repeat (3) tick();
    tar = 16'h3333;
    ccia = 1'b1;
    tick();
    wccr = 1'b1; ccrin = 16'hBEEF;
    tick();
    wccr = 1'b0;
    checks++;
    if (ccrn !== 16'h3333) begin errors++; $display("[TB] FAIL cap_over_wccr got %h want 3333", ccrn); end
  endtask

  task automatic test_edge_select();
    cap = 1'b1; cm = 2'd2; scs = 1'b0; ccia = 1'b1;
    repeat (4) tick();
    clear_flags();
    tar = 16'h4444;
    ccia = 1'b0;
    repeat (2) tick();
    checks++;
    if ({ccifg, ccrn} !== {1'b1, 16'h4444}) begin errors++; $display("[TB] FAIL fall_capture got %b/%h want 1/4444", ccifg, ccrn); end
    cm = 2'd0;
    clear_flags();
    tar = 16'h5555;
    ccia = 1'b1;
    repeat (3) tick();
    ccia = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ccifg, ccrn} !== {1'b0, 16'h4444}) begin errors++; $display("[TB] FAIL cm0_no_capture got %b/%h want 0/4444", ccifg, ccrn); end
  endtask

  task automatic test_reset_mid();
    cap = 1'b0; ccis = 2'd3; tar = 16'h00F0;
    wccr = 1'b1; ccrin = 16'h00FF;
    tick();
    wccr = 1'b0;
    clear_flags();
    tar = 16'h00FF;
    tick();
    checks++;
    if ({ccifg, ccrn} !== {1'b1, 16'h00FF}) begin errors++; $display("[TB] FAIL rst_pre got %b/%h want 1/00ff", ccifg, ccrn); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ccrn, ccifg, cov, scci} !== {16'h0000, 3'b000}) begin
      errors++; $display("[TB] FAIL rst_async got %h/%b%b%b want 0000/000", ccrn, ccifg, cov, scci);
    end
    tar = '0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({equn, ccifg} !== 2'b10) begin errors++; $display("[TB] FAIL rst_release got equn,ccifg=%b want 10", {equn, ccifg}); end
    tick();
    checks++;
    if (ccifg !== 1'b1) begin errors++; $display("[TB] FAIL rst_first_match got %b want 1", ccifg); end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_capture(1'b0);
    test_capture(1'b1);
    test_overflow();
    test_priority();
    test_edge_select();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccm_capture_compare.md
CCM_CAPTURE_COMPARE -- requirements
Module: ccm_capture_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the timer/CCR bit width.
REQ-002 SHALL have port TimerClock, input, 1 bit: timer clock shared with the TimerA base.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port TAR, input, WIDTH bits: current timer count.
REQ-005 SHALL have port CAP, input, 1 bit: 1 = capture mode, 0 = compare mode.
REQ-006 SHALL have port CM, input, 2 bits: capture edge select; 0 = none, 1 = rising, 2 = falling, 3 = both.
REQ-007 SHALL have port CCIS, input, 2 bits: input select; 0 = CCIA, 1 = CCIB, 2 = GND, 3 = VCC.
REQ-008 SHALL have port SCS, input, 1 bit: 1 = synchronous capture (extra sync stage).
REQ-009 SHALL have ports CCIA and CCIB, inputs, 1 bit each: external capture signals.
REQ-010 SHALL have ports wCCR (input, 1 bit, write strobe) and CCRin (input, WIDTH bits, write data).
REQ-011 SHALL have ports clrCCIFG and clrCOV, inputs, 1 bit each: software clear strobes.
REQ-012 SHALL have ports CCRn (output, WIDTH bits), EQUn, CCIFG, COV, SCCI and CCI (outputs, 1 bit each).

Function
REQ-013 SHALL drive CCI combinationally from the CCIS-selected source.
REQ-014 SHALL register CCI into a sample stage s1 every TimerClock rising edge.
REQ-015 SHALL take the edge-detect input from s1 when SCS=0, and from a second register s2 (fed by s1) when SCS=1, giving one extra cycle of latency.
REQ-016 SHALL hold the previous edge-detect sample in prev and define rise = cur & ~prev, fall = ~cur & prev.
REQ-017 SHALL assert a capture event, in capture mode, when (CM=1 & rise) | (CM=2 & fall) | (CM=3 & (rise|fall)); CM=0 never captures.
REQ-018 SHALL, on a capture event, load CCRn <= TAR at that same clock edge and set CCIFG.
REQ-019 SHALL set COV at the same edge if CCIFG is already 1 when a capture event occurs; COV SHALL clear only on clrCOV or reset.
REQ-020 SHALL give a capture event priority over a simultaneous wCCR (write discarded); otherwise wCCR loads CCRn <= CCRin in either mode.
REQ-021 SHALL, in compare mode, drive EQUn = (TAR == CCRn) combinationally; EQUn SHALL be 0 in capture mode.
REQ-022 SHALL keep a registered eqPrev; in compare mode, a rising TimerClock with EQUn=1 and eqPrev=0 SHALL set CCIFG and latch SCCI <= CCI.
REQ-023 SHALL set CCIFG only once per match while the timer is stopped on a match; it re-arms after EQUn deasserts for at least one clock.
REQ-024 SHALL give a hardware CCIFG set priority over a simultaneous clrCCIFG, and a hardware COV set priority over a simultaneous clrCOV.
REQ-025 SHALL, on a CAP change, leave CCRn, CCIFG and COV unchanged; eqPrev SHALL be forced to 0 while CAP=1.
REQ-026 SHALL compare and capture using exact WIDTH-bit values with no wrap logic; a TAR wrap is a normal value change.

Reset
REQ-027 SHALL, on asynchronous reset, clear immediately CCRn=0, CCIFG=0, COV=0, SCCI=0, s1=s2=prev=0 and eqPrev=0.
REQ-028 SHALL drive EQUn after reset from (TAR==0) only in compare mode; reset mid-capture SHALL abort the capture with no flag set.
REQ-029 SHALL resume operation on the first TimerClock rising edge after reset deasserts.

Verification
REQ-030 SHALL be covered by: compare mode, CCRn=0x0005, TAR counts 0..10 -> EQUn high only at TAR=5, CCIFG set one edge later, SCCI = CCI at that edge.
REQ-031 SHALL be covered by: capture mode, CM=1, SCS=0, CCIA rises while TAR=0x1234 -> CCRn=0x1234 (TAR value at the capture edge, 2 edges after the pin change), CCIFG=1, COV=0.
REQ-032 SHALL be covered by: the REQ-031 setup with SCS=1 -> capture occurs exactly one TimerClock later than with SCS=0.
REQ-033 SHALL be covered by: two rising CCIA edges with no clrCCIFG between them -> COV=1 and CCRn holds the second TAR value; then clrCOV -> COV=0 and CCIFG stays 1.
REQ-034 SHALL be covered by: a clrCCIFG pulse on the same edge as a compare match -> CCIFG remains 1; wCCR on the same edge as a capture -> CCRn = TAR, not CCRin.
REQ-035 SHALL be covered by: asserting reset mid-compare with CCRn=0x00FF -> all registers clear asynchronously; after release with TAR=0 in compare mode -> EQUn=1, and CCIFG sets on the next edge.
